// File: rtl/adc_avg_filter_pkg.sv
// Shared types and XADC constants for the averaging front end of the panel-voltage servo.
package adc_avg_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACC  = 2'd3
    } drp_state_t;

    localparam logic [4:0]  XADC_CH_VAUX0   = 5'h10;
    localparam logic [6:0]  XADC_ADDR_VAUX0 = 7'h10;

    // Conversion result sits left-justified in the 16-bit DRP word.
    localparam int unsigned RES_MSB = 15;
    localparam int unsigned RES_LSB = 4;
    localparam int unsigned RES_W   = RES_MSB - RES_LSB + 1;

endpackage

// File: rtl/adc_avg_filter_drp_read_ctrl.sv
// XADC DRP read handshake: one read per accepted EOC, DRDY timeout, sticky error flags.
module drp_read_ctrl
    import adc_avg_filter_pkg::*;
#(
    parameter logic [4:0]  CH_SEL  = XADC_CH_VAUX0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eoc,
    input  logic [4:0]        channel,
    input  logic              drdy,
    input  logic [15:0]       drp_do,
    output logic              den,
    output logic [RES_W-1:0]  sample,
    output logic              sample_strobe,
    output logic              overrun,
    output logic              to_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    drp_state_t state, state_next;
    logic [7:0] tcnt;
    logic       accept;
    logic       expire;
    logic       unused_do_lsbs;

    assign accept         = eoc && (channel == CH_SEL);
    assign expire         = (tcnt == TO_LAST);
    assign unused_do_lsbs = ^drp_do[RES_LSB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        den           = 1'b0;
        sample_strobe = 1'b0;
        case (state)
            IDLE: if (accept) state_next = REQ;
            REQ: begin
                den        = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // DRDY takes priority over an expiry on the same cycle.
                if (drdy)        state_next = ACC;
                else if (expire) state_next = IDLE;
            end
            ACC: begin
                sample_strobe = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt    <= '0;
            sample  <= '0;
            overrun <= 1'b0;
            to_err  <= 1'b0;
        end else begin
            case (state)
                REQ: tcnt <= '0;
                WAIT: begin
                    if (drdy)        sample <= drp_do[RES_MSB:RES_LSB];
                    else if (expire) to_err <= 1'b1;
                    else             tcnt   <= tcnt + 8'd1;
                end
                default: ;
            endcase
            if (accept && (state != IDLE)) overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Boxcar average of 2^LOG2_N XADC samples feeding the comparator/LCD path.
module adc_avg_filter
    import adc_avg_filter_pkg::*;
#(
    parameter int unsigned LOG2_N   = 4,
    parameter logic [6:0]  DRP_ADDR = XADC_ADDR_VAUX0,
    parameter logic [4:0]  CH_SEL   = XADC_CH_VAUX0,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EOC,
    input  logic [4:0]   CHANNEL,
    input  logic         DRDY,
    input  logic [15:0]  DO,
    output logic         DEN,
    output logic [6:0]   DADDR,
    output logic [11:0]  V_AVG,
    output logic         V_VALID,
    output logic         OVERRUN,
    output logic         TO_ERR
);

    localparam int unsigned ACC_W    = RES_W + LOG2_N;
    localparam logic [LOG2_N:0] CNT_FULL = {1'b1, {LOG2_N{1'b0}}};

    logic [RES_W-1:0]  sample;
    logic              sample_strobe;
    logic [ACC_W-1:0]  acc;
    logic [LOG2_N:0]   cnt;

    assign DADDR = DRP_ADDR;

    drp_read_ctrl #(
        .CH_SEL  (CH_SEL),
        .TIMEOUT (TIMEOUT)
    ) u_drp (
        .clk           (CLK),
        .rst           (RST),
        .eoc           (EOC),
        .channel       (CHANNEL),
        .drdy          (DRDY),
        .drp_do        (DO),
        .den           (DEN),
        .sample        (sample),
        .sample_strobe (sample_strobe),
        .overrun       (OVERRUN),
        .to_err        (TO_ERR)
    );

    // The average is published the cycle after the final sample lands in acc;
    // the next strobe is at least three cycles away, so clear and add never collide.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            cnt     <= '0;
            V_AVG   <= '0;
            V_VALID <= 1'b0;
        end else begin
            V_VALID <= 1'b0;
            if (cnt == CNT_FULL) begin
                V_AVG   <= acc[LOG2_N +: RES_W];
                V_VALID <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else if (sample_strobe) begin
                acc <= acc + ACC_W'(sample);
                cnt <= cnt + (LOG2_N + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter with LOG2_N=2 and TIMEOUT=8.
module tb_adc_avg_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eoc = 1'b0;
    logic [4:0]  channel = 5'h00;
    logic        drdy = 1'b0;
    logic [15:0] drp_do = 16'h0000;
    logic        den;
    logic [6:0]  daddr;
    logic [11:0] v_avg;
    logic        v_valid;
    logic        overrun;
    logic        to_err;

    int checks = 0;
    int errors = 0;
    int den_count = 0;
    int valid_count = 0;

    always #5 clk = ~clk;

    adc_avg_filter #(
        .LOG2_N  (2),
        .TIMEOUT (8)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .EOC     (eoc),
        .CHANNEL (channel),
        .DRDY    (drdy),
        .DO      (drp_do),
        .DEN     (den),
        .DADDR   (daddr),
        .V_AVG   (v_avg),
        .V_VALID (v_valid),
        .OVERRUN (overrun),
        .TO_ERR  (to_err)
    );

    always @(posedge clk) begin
        if (den)     den_count++;
        if (v_valid) valid_count++;
    end

    typedef struct {
        logic [3:0][11:0] s;
        int               dly;
        logic [11:0]      avg;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One DRP read: DRDY arrives dly cycles after the DEN cycle.
    task automatic read_sample(input logic [11:0] val, input int dly, input bit last,
                               input logic [11:0] exp_avg, input bit inject_ovr);
        eoc = 1'b1; channel = 5'h10;
        tick;
        eoc = 1'b0;
        chk("den_on", den, 1);
        tick;
        chk("den_off", den, 0);
        if (inject_ovr) begin eoc = 1'b1; channel = 5'h10; end
        for (int i = 1; i < dly; i++) begin
            tick;
            eoc = 1'b0;
        end
        drdy = 1'b1; drp_do = {val, 4'hA};
        tick;
        drdy = 1'b0; eoc = 1'b0; drp_do = 16'hDEAD;
        tick;
        chk("valid_early", v_valid, 0);
        tick;
        chk("valid_at_d2", v_valid, last);
        if (last) begin
            chk("v_avg", v_avg, exp_avg);
            tick;
            chk("valid_width", v_valid, 0);
            chk("v_avg_hold", v_avg, exp_avg);
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   den_before;
        int   valid_before;

        vecs[0] = '{s: {12'd401, 12'd300, 12'd200, 12'd100}, dly: 3, avg: 12'd250};
        vecs[1] = '{s: {12'd3, 12'd0, 12'd0, 12'd0},         dly: 1, avg: 12'd0};
        vecs[2] = '{s: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, dly: 5, avg: 12'hFFF};
        vecs[3] = '{s: {12'd4, 12'd3, 12'd2, 12'd1},         dly: 8, avg: 12'd2};
        vecs[4] = '{s: {12'd41, 12'd40, 12'd40, 12'd40},     dly: 2, avg: 12'd40};

        // Reset state
        tick; tick; tick;
        chk("rst_den", den, 0);
        chk("rst_v_avg", v_avg, 0);
        chk("rst_v_valid", v_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_to_err", to_err, 0);
        chk("daddr", daddr, 7'h10);
        rst = 1'b0;
        tick;

        // Table of full averages; vector 3 lands DRDY exactly on the expiry cycle
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++)
                read_sample(vecs[v].s[k], vecs[v].dly, (k == 3), vecs[v].avg, 1'b0);
        end
        chk("to_err_drdy_on_expiry", to_err, 0);
        chk("overrun_clean", overrun, 0);

        // Foreign channel EOC mid-average must be ignored
        read_sample(12'd5, 2, 1'b0, 12'd0, 1'b0);
        den_before = den_count;
        eoc = 1'b1; channel = 5'h03;
        tick;
        eoc = 1'b0;
        chk("foreign_den", den, 0);
        tick;
        chk("foreign_den2", den, 0);
        chk("foreign_den_count", den_count - den_before, 0);
        for (int k = 0; k < 3; k++) read_sample(12'd5, 2, (k == 2), 12'd5, 1'b0);

        // DRDY withheld: timeout after 8 WAIT cycles, sample discarded
        den_before = den_count;
        eoc = 1'b1; channel = 5'h10;
        tick;
        eoc = 1'b0;
        chk("to_den", den, 1);
        for (int i = 0; i < 8; i++) tick;
        chk("to_err_before_expiry", to_err, 0);
        tick;
        chk("to_err_set", to_err, 1);
        chk("to_den_count", den_count - den_before, 1);
        for (int k = 0; k < 4; k++) read_sample(12'hFFF, 3, (k == 3), 12'hFFF, 1'b0);
        chk("to_err_sticky", to_err, 1);

        // Overlapping EOC one cycle after DEN: dropped, first read still counts
        den_before = den_count;
        read_sample(12'd20, 3, 1'b0, 12'd0, 1'b1);
        chk("overrun_set", overrun, 1);
        chk("overrun_single_den", den_count - den_before, 1);
        for (int k = 0; k < 3; k++) read_sample(12'd4, 2, (k == 2), 12'd8, 1'b0);
        chk("overrun_sticky", overrun, 1);

        // Reset during WAIT after two samples; a late DRDY must be ignored
        read_sample(12'd1000, 2, 1'b0, 12'd0, 1'b0);
        read_sample(12'd1000, 2, 1'b0, 12'd0, 1'b0);
        eoc = 1'b1; channel = 5'h10;
        tick;
        eoc = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        den_before = den_count;
        valid_before = valid_count;
        chk("mid_rst_v_avg", v_avg, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_to_err", to_err, 0);
        chk("mid_rst_den", den, 0);
        drdy = 1'b1; drp_do = {12'd1000, 4'h0};
        tick;
        drdy = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        chk("late_drdy_valid", valid_count - valid_before, 0);
        chk("late_drdy_den", den_count - den_before, 0);
        chk("late_drdy_v_avg", v_avg, 0);
        for (int k = 0; k < 4; k++) read_sample(12'd40, 3, (k == 3), 12'd40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_avg_filter.md
Name: adc_avg_filter

Overview:
- Sits directly upstream of the voltage comparator, flip-flop array and LCD; replaces the raw XADC-to-V_in connection.
- Owns the XADC DRP read handshake: on each end-of-conversion for the selected channel it issues one DRP read and captures the 12-bit result.
- Boxcar-averages 2^LOG2_N samples and presents a stable averaged panel voltage with a one-cycle valid strobe, so servo sweep decisions ignore ADC noise.

Parameters:
- LOG2_N, 4, log2 of samples per average (1..8).
- DRP_ADDR, 7'h10, DRP status register address read on each conversion (VAUX0).
- CH_SEL, 5'h10, XADC channel number whose EOC is accepted.
- TIMEOUT, 64, max CLK cycles to wait for DRDY after DEN (2..255).

Ports:
- CLK  in  1  system clock (PLL clock domain, same as xadc dclk_in)
- RST  in  1  synchronous, active-high reset
- EOC  in  1  XADC eoc_out, one-cycle pulse
- CHANNEL  in  5  XADC channel_out, valid when EOC high
- DRDY  in  1  XADC drdy_out
- DO  in  16  XADC do_out; result in DO[15:4]
- DEN  out  1  DRP enable to XADC, one-cycle pulse
- DADDR  out  7  DRP address, constant DRP_ADDR
- V_AVG  out  12  averaged voltage code
- V_VALID  out  1  one-cycle pulse when V_AVG updates
- OVERRUN  out  1  sticky: accepted EOC arrived while a read was outstanding
- TO_ERR  out  1  sticky: DRDY timeout occurred

Behaviour:
- Reset values: DEN=0, V_AVG=0, V_VALID=0, OVERRUN=0, TO_ERR=0. Accumulator, sample counter and timeout counter are cleared; FSM goes to IDLE. DADDR is always DRP_ADDR.
- Reset asserted mid-read: the read is abandoned and the partial sum discarded. A late DRDY after reset is ignored because the FSM is in IDLE.
- FSM states:
  - IDLE: EOC=1 and CHANNEL==CH_SEL -> REQ. EOC on any other channel is ignored.
  - REQ: DEN=1 for exactly this one cycle; timeout counter cleared; -> WAIT.
  - WAIT: DRDY=1 -> capture DO[15:4] and go to ACC. Otherwise the timeout counter increments; when it reaches TIMEOUT-1 with DRDY=0, set TO_ERR, discard the sample (no accumulate, no count) and go to IDLE. If DRDY and expiry coincide, DRDY wins.
  - ACC: acc += sample; cnt += 1; -> IDLE.
- Latency: EOC at edge t -> DEN high in cycle t+1. DRDY sampled at edge d -> accumulation at d+1. For the Nth sample, V_AVG and V_VALID update at d+2.
- Accumulator width is 12+LOG2_N; no overflow is possible.
- On the sample that makes cnt == 2^LOG2_N: V_AVG = (acc+sample)>>LOG2_N, truncated toward zero. V_VALID=1 for one cycle. acc and cnt clear in the same cycle.
- V_AVG holds between updates.
- An accepted-channel EOC while in REQ/WAIT/ACC sets OVERRUN; that EOC is dropped, not queued.
- DRDY outside WAIT is ignored.
- OVERRUN and TO_ERR clear only on RST.
- Sample counter width is LOG2_N+1; it wraps to 0 after each completed average.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, ACC=2'd3
  - XADC constants: VAUX0 channel 5'h10, status address 7'h10
  - result bit slice positions [15:4]
- One natural sub-module, drp_read_ctrl: the IDLE/REQ/WAIT handshake plus timeout. It returns a sample and a sample_strobe to a top level that holds the accumulator and averager.

Test Plan:
- LOG2_N=2; four accepted EOCs, DRDY 3 cycles after each DEN, DO[15:4]=100,200,300,401 -> single V_VALID pulse, V_AVG=250 (1001>>2), at 2 cycles after the 4th DRDY.
- EOC with CHANNEL=5'h03 -> no DEN, counters unchanged. Then EOC with CHANNEL=5'h10 -> DEN high exactly 1 cycle, next edge after EOC.
- TIMEOUT=8, DRDY withheld -> TO_ERR=1 after 8 WAIT cycles and FSM back in IDLE. The next 4 good samples of 12'hFFF -> V_AVG=12'hFFF (timed-out sample not counted).
- Second accepted EOC 1 cycle after DEN -> OVERRUN=1, only one DEN issued. The first read still completes and is accumulated.
- RST pulsed in WAIT after 2 of 4 samples, then DRDY arrives -> ignored. All outputs 0. The next 4 samples of 40 -> V_AVG=40.
- DRDY on the same cycle as timeout expiry -> sample accepted, TO_ERR stays 0.
